alu_iter: RTL
=============

Name: alu_iter

Overview:
Parametrised multi-cycle successor to the datapath ALU.
- ADD/SUB complete in one registered cycle.
- DIV/REM use a true iterative restoring divider: one quotient bit per clock, exact quotient and remainder.
- Valid/ready handshakes on both sides let the pipeline control stall on long operations.
- Sits between the register-file read stage and writeback.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CTRL_W, 4, width of aluctrl opcode field

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block can accept a new operation
aluctrl  input  CTRL_W  opcode: 1 ADD, 2 SUB, 3 DIV (quotient), 4 REM; all others NOP
data_s  input  WIDTH  operand s (dividend)
data_t  input  WIDTH  operand t (divisor)
out_valid  output  1  result, zero and dz valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  1 when result == 0
dz  output  1  1 when a DIV/REM had data_t == 0

Behaviour:
- Reset (async, rstn=0): state=IDLE; result=0, zero=0, dz=0, out_valid=0; in_ready=0 while rstn low.
- Reset mid-operation aborts the division; no partial result is ever presented.
- States: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready; operands and opcode are latched at the accept edge.
  - ADD/SUB/NOP: result computed and registered on the accept edge; -> DONE.
  - ADD/SUB wrap modulo 2^WIDTH, no carry/overflow output.
  - NOP gives result 0, zero=1.
  - DIV/REM with data_t==0: -> DONE immediately; DIV result all-ones, REM result = data_s, dz=1.
  - DIV/REM with data_t!=0: load remainder=0, quotient=data_s, counter=WIDTH; -> DIV.
- DIV:
  - Each cycle: shift {rem,quot} left 1, trial = rem_shifted - divisor (WIDTH+1 bits).
  - If trial non-negative: rem=trial, quotient LSB=1; else quotient LSB=0.
  - Counter decrements; at counter==1 the final iteration writes result (quot for DIV, rem for REM); -> DONE.
  - Exactly WIDTH cycles in DIV; in_ready=0; input changes are ignored.
- DONE:
  - out_valid=1; result/zero/dz stable until handshake.
  - On out_ready=1 -> IDLE, out_valid=0 next cycle.
  - in_ready=0 in DONE; no overlap of a new accept with output drain.
- Latency, accept edge to out_valid high: ADD/SUB/NOP/div-by-zero 1 cycle; DIV/REM WIDTH+1 cycles.
- zero and dz are registered alongside result. dz clears on next accepted op.
- All arithmetic is unsigned unless the optional feature is compiled in.

Optional Feature:
ALU_SIGNED_DIV_EN
- Defined:
  - Adds opcodes 5 DIVS and 6 REMS (two's complement).
  - Operands are converted to magnitudes on accept; the same unsigned datapath is used.
  - Sign correction applies in the DONE transition: quotient negative if signs differ; remainder takes the sign of data_s.
  - Latency unchanged.
  - Overflow case: most-negative / -1 gives DIVS = most-negative, REMS = 0, dz=0.
  - DIVS/REMS by zero behave as unsigned (all-ones / data_s, dz=1).
- Not defined: opcodes 5 and 6 are NOP.

Decomposition:
- Package alu_pkg: opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_DIV, OP_REM, OP_DIVS, OP_REMS), state enum encoding (S_IDLE, S_DIV, S_DONE).
- One natural sub-module: div_step, combinational single restoring iteration (rem, quot bit-in, divisor -> next rem, next quot), instantiated once inside alu_iter.

Test Plan:
- Reset, then ADD 0xFFFFFFFF+1 -> out_valid 1 cycle after accept, result 0, zero=1; SUB 5-7 -> 0xFFFFFFFE.
- DIV 100/7 -> result 14 after exactly 33 cycles; REM 100/7 -> result 2; in_ready=0 throughout; data_s toggled mid-divide has no effect.
- DIV 1234/0 -> result 0xFFFFFFFF, dz=1, 1-cycle latency; REM 1234/0 -> 1234, dz=1.
- Backpressure: out_ready held low 10 cycles after DIV 0xFFFFFFFF/1 -> result 0xFFFFFFFF stable, out_valid held, in_ready=0; release -> IDLE next cycle.
- rstn pulsed low at DIV cycle 12 -> outputs 0 immediately, no out_valid; next DIV 9/3 -> 3.
- With ALU_SIGNED_DIV_EN: DIVS -7/2 -> -3 (0xFFFFFFFD), REMS -7/2 -> -1; DIVS 0x80000000/-1 -> 0x80000000. WIDTH=8 build: DIV 200/3 -> 66 in 9 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode values and state encoding for the iterative ALU.
package alu_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_REM  = 4;
    localparam int OP_DIVS = 5;
    localparam int OP_REMS = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left by one, trial
// subtract the divisor, keep the difference only if it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder is below 2*divisor, so bit WIDTH of the
    // (WIDTH+1)-bit difference is a reliable sign bit.
    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o  = trial[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = shifted[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle ADD/SUB, bit-serial restoring DIV/REM.
// Optional feature macro: ALU_SIGNED_DIV_EN adds signed DIVS/REMS (opcodes
// 5/6); without it those opcodes behave as NOP.
//
// state  | meaning
// IDLE   | waiting for an operation, in_ready high
// DIV    | one quotient bit per clock, WIDTH clocks
// DONE   | result held with out_valid high until out_ready
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] aluctrl,
    input  logic [WIDTH-1:0]  data_s,
    input  logic [WIDTH-1:0]  data_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_rem_q, is_rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;
`ifdef ALU_SIGNED_DIV_EN
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
`endif

    logic               op_add, op_sub, op_div, op_rem, op_signed;
    logic [WIDTH-1:0]   s_mag, t_mag;
    logic [WIDTH-1:0]   arith_res;
    logic [WIDTH-1:0]   dz_res;
    logic [WIDTH-1:0]   step_rem, step_quot;
    logic [WIDTH-1:0]   final_res;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Opcode decode; signed variants fold onto the unsigned divider.
    always_comb begin
        op_add    = (aluctrl == CTRL_W'(OP_ADD));
        op_sub    = (aluctrl == CTRL_W'(OP_SUB));
        op_div    = (aluctrl == CTRL_W'(OP_DIV));
        op_rem    = (aluctrl == CTRL_W'(OP_REM));
        op_signed = 1'b0;
`ifdef ALU_SIGNED_DIV_EN
        if (aluctrl == CTRL_W'(OP_DIVS)) begin
            op_div    = 1'b1;
            op_signed = 1'b1;
        end
        if (aluctrl == CTRL_W'(OP_REMS)) begin
            op_rem    = 1'b1;
            op_signed = 1'b1;
        end
`endif
    end

    // Operand magnitudes, single-cycle results and divide-by-zero results.
    always_comb begin
        s_mag = (op_signed && data_s[WIDTH-1]) ? (~data_s + 1'b1) : data_s;
        t_mag = (op_signed && data_t[WIDTH-1]) ? (~data_t + 1'b1) : data_t;
        if (op_add) begin
            arith_res = data_s + data_t;
        end else if (op_sub) begin
            arith_res = data_s - data_t;
        end else begin
            arith_res = '0;
        end
        dz_res = op_div ? {WIDTH{1'b1}} : data_s;
    end

    // Value written on the last divide iteration, sign-corrected if needed.
    always_comb begin
        final_res = is_rem_q ? step_rem : step_quot;
`ifdef ALU_SIGNED_DIV_EN
        if (is_rem_q ? neg_rem_q : neg_quot_q) begin
            final_res = ~final_res + 1'b1;
        end
`endif
    end

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        zero_d    = zero_q;
        dz_d      = dz_q;
`ifdef ALU_SIGNED_DIV_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dz_d = 1'b0;
                    if (op_div || op_rem) begin
                        if (data_t == '0) begin
                            result_d = dz_res;
                            zero_d   = (dz_res == '0);
                            dz_d     = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            rem_d     = '0;
                            quot_d    = s_mag;
                            divisor_d = t_mag;
                            cnt_d     = CNT_W'(WIDTH);
                            is_rem_d  = op_rem;
`ifdef ALU_SIGNED_DIV_EN
                            neg_quot_d = op_signed && (data_s[WIDTH-1] ^ data_t[WIDTH-1]);
                            neg_rem_d  = op_signed && data_s[WIDTH-1];
`endif
                            state_d   = S_DIV;
                        end
                    end else begin
                        result_d = arith_res;
                        zero_d   = (arith_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_DIV: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            dz_q      <= 1'b0;
`ifdef ALU_SIGNED_DIV_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            dz_q      <= dz_d;
`ifdef ALU_SIGNED_DIV_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    // in_ready is gated by rstn so it reads low for the whole reset window.
    always_comb begin
        in_ready  = rstn && (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
        zero      = zero_q;
        dz        = dz_q;
    end

endmodule
